demux_1to4_pipe: RTL and testbench
==================================

// Module: demux_1to4_pipe
// PURPOSE
//  Registered 1-to-4 demultiplexer: the write-side counterpart of the 4-way routing mux.
//  Accepts one word plus a 2-bit lane select over a valid/ready handshake.
//  Holds the word in a single-entry pipeline register and presents it on the selected
//  output lane only, with per-lane valid/ready.
//  Sits between datapath producers and up to four consumers, e.g. the write-back fan-out.
// PARAMETERS
//  WIDTH   1   data bits routed per word
//  CNT_W   8   width of each per-lane transfer counter
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  reset      in   1          synchronous, active-high reset
//  in_valid   in   1          input word valid
//  in_ready   out  1          block can accept input this cycle
//  in_data    in   WIDTH      word to route
//  in_sel     in   2          destination lane 0..3, sampled with in_data
//  out_valid  out  4          one-hot; bit k = lane k holds a word
//  out_ready  in   4          lane k consumer ready
//  out_data   out  4*WIDTH    lane k at [k*WIDTH +: WIDTH]; unselected lanes driven 0
//  xfer_cnt   out  4*CNT_W    lane k completed transfers at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset, synchronous: state=EMPTY, hold_data=0, hold_sel=0, xfer_cnt=0.
//    Consequently out_valid=0 and out_data=0. in_ready=0 while reset is high.
//  - State EMPTY (full=0):
//      out_valid=0; in_ready=1.
//      accept (in_valid&&in_ready) -> FULL; latch in_data, in_sel.
//  - State FULL (full=1):
//      out_valid = onehot(hold_sel); out_data lane hold_sel = hold_data.
//  - Fire: full && out_ready[hold_sel]. out_ready on non-selected lanes is ignored.
//  - in_ready = !full || out_ready[hold_sel]. Combinational; no in_valid->in_ready path.
//  - Transitions out of FULL:
//      fire && !accept    -> EMPTY.
//      fire && accept     -> stay FULL; new word replaces old the same edge
//                            (1 word/cycle sustained).
//      !fire              -> hold; hold_data/hold_sel stable, in_ready=0.
//  - Latency: accepted word visible on out_valid/out_data the cycle after the accept edge.
//  - Counters: xfer_cnt[hold_sel] += 1 on each fire; wraps 2^CNT_W-1 -> 0. Other lanes unchanged.
//  - Reset mid-operation: held word discarded, no fire counted that cycle,
//    counters cleared, in_ready=0 that cycle.
//  - in_sel is don't-care when in_valid=0. No X propagation from idle inputs into state.
//  - No lane may see valid without an accepted word. Exactly one or zero out_valid bits set.
// STRUCTURE
//  - Shared include demux_defs.vh:
//      `DEMUX_LANES=4, `DEMUX_SEL_W=2
//      state encoding ST_EMPTY=1'b0, ST_FULL=1'b1
//  - Sub-module demux_decode2to4 (combinational sel[1:0] + en -> onehot[3:0]).
//    Used for out_valid and for counter enables.
//  - Top: state/hold registers, handshake logic, 4 counters, lane data gating.
// TESTING
//  1. Reset then idle: out_valid=4'b0000, out_data=0, xfer_cnt all 0, in_ready=1 after reset drops.
//  2. Single word, WIDTH=1: in_data=1, in_sel=2, out_ready=4'b1111
//     -> next cycle out_valid=4'b0100, lane2 data=1; fire; xfer_cnt lane2=1.
//  3. Stall: word sel=3 held with out_ready[3]=0, out_ready[0..2]=1 for 5 cycles
//     -> out_valid=4'b1000 stable, in_ready=0, no counts; out_ready[3]=1 -> fire, cnt3=1.
//  4. Back-to-back: 8 words, sel 0,1,2,3,0,1,2,3, all ready
//     -> in_ready=1 every cycle, one output per cycle in order, final counts 2,2,2,2.
//  5. Wrap: CNT_W=2, 5 fires on lane1 -> xfer_cnt lane1 = 1.
//  6. Reset while FULL with out_ready=0 -> next cycle out_valid=0, counters 0,
//     held word never appears.

Source files
------------

// File: rtl/demux_1to4_pipe_pkg.sv
// demux_1to4_pipe_pkg: shared lane count, select width and state encoding
package demux_1to4_pipe_pkg;
  localparam int DEMUX_LANES = 4;
  localparam int DEMUX_SEL_W = 2;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;
endpackage

// File: rtl/demux_1to4_pipe_decode.sv
// demux_decode2to4: enabled 2-to-4 one-hot decoder
module demux_decode2to4
  import demux_1to4_pipe_pkg::*;
(
  input  logic [DEMUX_SEL_W-1:0] sel,
  input  logic                   en,
  output logic [DEMUX_LANES-1:0] onehot
);
  // one bit set for the selected lane, none when disabled
  always_comb onehot = en ? DEMUX_LANES'(1) << sel : '0;
endmodule

// File: rtl/demux_1to4_pipe.sv
// demux_1to4_pipe: single-entry registered 1-to-4 demux with per-lane handshake and transfer counters
module demux_1to4_pipe
  import demux_1to4_pipe_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [DEMUX_SEL_W-1:0]       in_sel,
  output logic [DEMUX_LANES-1:0]       out_valid,
  input  logic [DEMUX_LANES-1:0]       out_ready,
  output logic [DEMUX_LANES*WIDTH-1:0] out_data,
  output logic [DEMUX_LANES*CNT_W-1:0] xfer_cnt
);
  logic [0:0] state;
  logic [WIDTH-1:0] hold_data;
  logic [DEMUX_SEL_W-1:0] hold_sel;
  logic full, fire, accept;
  logic [DEMUX_LANES-1:0] fire_oh;
  logic [CNT_W-1:0] cnt [DEMUX_LANES];
  demux_decode2to4 u_dec (
    .sel(hold_sel),
    .en(full),
    .onehot(out_valid)
  );
  // handshake: a slot frees up either when empty or when the held word leaves this cycle
  always_comb begin
    full = state == ST_FULL;
    fire = full && out_ready[hold_sel];
    in_ready = !reset && (!full || out_ready[hold_sel]);
    accept = in_valid && in_ready;
    fire_oh = out_valid & out_ready;
  end
  // hold register: load on accept, drain to empty on a fire with no replacement
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      hold_data <= '0;
      hold_sel <= '0;
    end else if (accept) begin
      state <= ST_FULL;
      hold_data <= in_data;
      hold_sel <= in_sel;
    end else if (fire) state <= ST_EMPTY;
  end
  for (genvar k = 0; k < DEMUX_LANES; k++) begin : g_lane
    // per-lane completed-transfer counter, wraps naturally
    always_ff @(posedge clk) begin
      if (reset) cnt[k] <= '0;
      else if (fire_oh[k]) cnt[k] <= cnt[k] + CNT_W'(1);
    end
    assign out_data[k*WIDTH +: WIDTH] = out_valid[k] ? hold_data : '0;
    assign xfer_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
endmodule

// File: tb/tb_demux_1to4_pipe.sv
// tb_demux_1to4_pipe: directed plus randomized check of two demux configurations against a queue model
module tb_demux_1to4_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_valid, chk_on;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_ready;
  logic a_in_ready, b_in_ready;
  logic [3:0] a_out_valid, b_out_valid, b_out_data;
  logic [31:0] a_out_data, a_xfer;
  logic [7:0] b_xfer;
  int tests = 0, fails = 0;
  demux_1to4_pipe #(.WIDTH(8), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .xfer_cnt(a_xfer)
  );
  demux_1to4_pipe #(.WIDTH(1), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data[0]), .in_sel(in_sel), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .xfer_cnt(b_xfer)
  );
  typedef struct { logic [7:0] d; logic [1:0] s; } word_t;
  word_t q[$];
  int cnt[4];
  function automatic logic exp_ready();
    return !reset && (q.size() == 0 || out_ready[q[0].s]);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  // model: a one-deep queue; head leaves when its lane is ready, a new word enters if there was room
  always @(posedge clk) begin
    logic rdy;
    rdy = exp_ready();
    if (reset) begin
      q.delete();
      foreach (cnt[k]) cnt[k] = 0;
    end else begin
      if (q.size() != 0 && out_ready[q[0].s]) begin
        cnt[q[0].s]++;
        void'(q.pop_front());
      end
      if (in_valid && rdy) q.push_back('{in_data, in_sel});
    end
  end
  always @(negedge clk) begin
    logic [3:0] ev, ebd;
    logic [31:0] ead, eax;
    logic [7:0] ebx;
    if (chk_on) begin
      ev = 4'b0000;
      ead = 32'h0;
      ebd = 4'b0000;
      if (q.size() != 0) begin
        ev[q[0].s] = 1'b1;
        ead[q[0].s*8 +: 8] = q[0].d;
        ebd[q[0].s] = q[0].d[0];
      end
      for (int k = 0; k < 4; k++) begin
        eax[k*8 +: 8] = 8'(cnt[k]);
        ebx[k*2 +: 2] = 2'(cnt[k]);
      end
      chk("a_in_ready", 32'(a_in_ready), 32'(exp_ready()));
      chk("b_in_ready", 32'(b_in_ready), 32'(exp_ready()));
      chk("a_out_valid", 32'(a_out_valid), 32'(ev));
      chk("b_out_valid", 32'(b_out_valid), 32'(ev));
      chk("a_out_data", a_out_data, ead);
      chk("b_out_data", 32'(b_out_data), 32'(ebd));
      chk("a_xfer_cnt", a_xfer, eax);
      chk("b_xfer_cnt", 32'(b_xfer), 32'(ebx));
    end
  end
  initial begin
    chk_on = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_sel = 2'd0;
    out_ready = 4'h0;
    tick();
    tick();
    chk_on = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(a_out_valid), 32'h0);
    chk("idle_data", a_out_data, 32'h0);
    chk("idle_cnt", a_xfer, 32'h0);
    chk("idle_ready", 32'(a_in_ready), 32'h1);
    tick();
    in_valid = 1'b1;
    in_data = 8'h01;
    in_sel = 2'd2;
    out_ready = 4'hf;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", 32'(a_out_valid), 32'h4);
    chk("single_data_a", a_out_data, 32'h0001_0000);
    chk("single_data_b", 32'(b_out_data), 32'h4);
    tick();
    @(negedge clk);
    chk("single_cnt_a", a_xfer, 32'h0001_0000);
    chk("single_cnt_b", 32'(b_xfer), 32'h10);
    do_reset();
    tick();
    in_valid = 1'b1;
    in_data = 8'ha5;
    in_sel = 2'd3;
    out_ready = 4'b0111;
    tick();
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(a_out_valid), 32'h8);
      chk("stall_ready", 32'(a_in_ready), 32'h0);
      chk("stall_cnt", a_xfer, 32'h0);
      tick();
    end
    out_ready = 4'hf;
    @(negedge clk);
    chk("stall_release_ready", 32'(a_in_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("stall_cnt3", a_xfer, 32'h0100_0000);
    do_reset();
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i + 16);
      in_sel = 2'(i);
      out_ready = 4'hf;
      @(negedge clk);
      chk("b2b_ready", 32'(a_in_ready), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("b2b_cnt_a", a_xfer, 32'h0202_0202);
    chk("b2b_cnt_b", 32'(b_xfer), 32'haa);
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      in_sel = 2'd1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("wrap_cnt_b", 32'(b_xfer), 32'h04);
    chk("wrap_cnt_a", a_xfer, 32'h0000_0500);
    tick();
    in_valid = 1'b1;
    in_data = 8'h5a;
    in_sel = 2'd0;
    out_ready = 4'h0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_full_valid", 32'(a_out_valid), 32'h1);
    tick();
    reset = 1'b1;
    out_ready = 4'hf;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(a_out_valid), 32'h0);
    chk("rst_cnt", a_xfer, 32'h0);
    tick();
    @(negedge clk);
    chk("rst_no_ghost", 32'(a_out_valid), 32'h0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_sel = 2'($urandom);
      out_ready = 4'($urandom);
    end
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
